// File: rtl/wb_pkg.sv
// ---------------------------------------------------------------------------
// wb_pkg
// Shared definitions for the Wishbone slave decoder / response mux.
//   - wb_state_t : FSM state encoding (IDLE=0, BUSY=1, RESP=2)
//   - WB_DW      : Wishbone data width
//   - slice_lo   : LSB of slave k's read-data slice in the packed s_data_i bus
//   - sel_mapped : true when a decoded select addresses an attached slave
// ---------------------------------------------------------------------------
package wb_pkg;

    localparam int WB_DW      = 32;
    localparam int MAX_SLAVES = 16;
    localparam int TIMER_W    = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } wb_state_t;

    function automatic int slice_lo(input int k);
        return k * WB_DW;
    endfunction

    // The select is widened to 32 bits so that the compare stays a real
    // run-time compare even when every select code maps to a slave.
    function automatic logic sel_mapped(input logic [31:0] sel, input int n_slaves);
        return sel < 32'(n_slaves);
    endfunction

endpackage

// File: rtl/wb_timeout.sv
// ---------------------------------------------------------------------------
// wb_timeout
// Saturating up-counter that flags a slave that has not acknowledged.
// The count holds at TIMEOUT-1, so expired stays high until cleared.
// Ports:
//   clock   in  : system clock, rising edge
//   reset   in  : asynchronous active-low reset (count -> 0)
//   clear   in  : synchronous clear, takes priority over enable
//   enable  in  : advance the count by one this cycle
//   expired out : count == TIMEOUT-1
// ---------------------------------------------------------------------------
module wb_timeout
    import wb_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [TIMER_W-1:0] LAST = TIMER_W'(TIMEOUT - 1);

    logic [TIMER_W-1:0] count;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != LAST)) begin
            count <= count + TIMER_W'(1);
        end
    end

    assign expired = (count == LAST);

endmodule

// File: rtl/wb_slave_mux.sv
// ---------------------------------------------------------------------------
// wb_slave_mux
// Classic single-master Wishbone slave decoder and response mux. A request
// is steered to one of N_SLAVES slaves by the address field
// wb_addr_i[SEL_LO +: SEL_W]. The target is latched per transaction, the
// response (data, ack, err) is registered, unmapped selects and silent
// slaves are answered with an error pulse.
//
// Ports:
//   clock        in  : system clock, rising edge
//   reset        in  : asynchronous active-low reset
//   wb_data_i    in  : master write data (broadcast to slaves externally)
//   wb_addr_i    in  : master address (broadcast to slaves externally)
//   wb_cyc_i     in  : master cycle
//   wb_strobe_i  in  : master strobe
//   wb_we_i      in  : master write enable (broadcast externally)
//   wb_data_o    out : registered read data, held until the next capture
//   wb_ack_o     out : registered success pulse, one cycle
//   wb_err_o     out : registered error pulse, one cycle
//   s_strobe_o   out : per-slave strobe, one-hot or zero (combinational)
//   s_data_i     in  : packed slave read data, slave k at [32k+31:32k]
//   s_ack_i      in  : per-slave ack
//   busy_o       out : high whenever the FSM is not in IDLE
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for cyc & stb; decodes the select field
// BUSY  | strobing the latched slave, waiting for its ack or the timeout
// RESP  | ack or err pulse is on the bus for exactly this cycle
// ---------------------------------------------------------------------------
module wb_slave_mux
    import wb_pkg::*;
#(
    parameter int N_SLAVES = 4,
    parameter int SEL_LO   = 16,
    parameter int SEL_W    = 2,
    parameter int TIMEOUT  = 64
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [WB_DW-1:0]          wb_data_i,
    input  logic [31:0]               wb_addr_i,
    input  logic                      wb_cyc_i,
    input  logic                      wb_strobe_i,
    input  logic                      wb_we_i,
    output logic [WB_DW-1:0]          wb_data_o,
    output logic                      wb_ack_o,
    output logic                      wb_err_o,
    output logic [N_SLAVES-1:0]       s_strobe_o,
    input  logic [WB_DW*N_SLAVES-1:0] s_data_i,
    input  logic [N_SLAVES-1:0]       s_ack_i,
    output logic                      busy_o
);

    wb_state_t           state;
    logic [SEL_W-1:0]    sel_q;
    logic [SEL_W-1:0]    sel_in;
    logic                req;
    logic                mapped;
    logic [N_SLAVES-1:0] sel_onehot;
    logic [WB_DW-1:0]    sel_data;
    logic                ack_hit;
    logic                expired;
    logic                timer_clear;
    logic                timer_enable;

    // Write data and write enable go to the slaves on external wiring; the
    // mux itself only needs the select bits of the address.
    logic unused_inputs;
    assign unused_inputs = ^{wb_data_i, wb_we_i, wb_addr_i};

    assign sel_in = wb_addr_i[SEL_LO +: SEL_W];
    assign req    = wb_cyc_i & wb_strobe_i;
    assign mapped = sel_mapped(32'(sel_in), N_SLAVES);

    // One-hot of the latched target; drives strobe, ack qualification and
    // the data mux so that no variable-width index is needed.
    always_comb begin
        sel_onehot = '0;
        for (int k = 0; k < N_SLAVES; k++) begin
            sel_onehot[k] = (32'(sel_q) == 32'(k));
        end
    end

    always_comb begin
        sel_data = '0;
        for (int k = 0; k < N_SLAVES; k++) begin
            if (sel_onehot[k]) begin
                sel_data = sel_data | s_data_i[slice_lo(k) +: WB_DW];
            end
        end
    end

    // Acks from slaves other than the latched one are masked off here.
    assign ack_hit = |(s_ack_i & sel_onehot);

    assign s_strobe_o = ((state == ST_BUSY) && wb_strobe_i) ? sel_onehot : '0;

    // Held clear throughout IDLE, so the count is 0 on the first BUSY cycle.
    assign timer_clear  = (state == ST_IDLE);
    assign timer_enable = (state == ST_BUSY);

    wb_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clock   (clock),
        .reset   (reset),
        .clear   (timer_clear),
        .enable  (timer_enable),
        .expired (expired)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            sel_q     <= '0;
            wb_data_o <= '0;
            wb_ack_o  <= 1'b0;
            wb_err_o  <= 1'b0;
            busy_o    <= 1'b0;
        end else begin
            // Pulses default low; only the transition into RESP raises one.
            wb_ack_o <= 1'b0;
            wb_err_o <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (req) begin
                        busy_o <= 1'b1;
                        if (mapped) begin
                            sel_q <= sel_in;
                            state <= ST_BUSY;
                        end else begin
                            wb_data_o <= '0;
                            wb_err_o  <= 1'b1;
                            state     <= ST_RESP;
                        end
                    end
                end

                ST_BUSY: begin
                    // A dropped cycle wins over everything: no response.
                    if (!wb_cyc_i) begin
                        state  <= ST_IDLE;
                        busy_o <= 1'b0;
                    end else if (ack_hit) begin
                        // Ack checked before the timeout so a last-cycle
                        // ack still completes successfully.
                        wb_data_o <= sel_data;
                        wb_ack_o  <= 1'b1;
                        state     <= ST_RESP;
                    end else if (expired) begin
                        wb_data_o <= '0;
                        wb_err_o  <= 1'b1;
                        state     <= ST_RESP;
                    end
                end

                ST_RESP: begin
                    state  <= ST_IDLE;
                    busy_o <= 1'b0;
                end

                default: begin
                    state  <= ST_IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_slave_mux.sv
module tb_wb_slave_mux;

    logic         clock = 1'b0;
    logic         reset = 1'b1;

    // Main DUT: 4 slaves, TIMEOUT 8
    logic [31:0]  wdata = '0;
    logic [31:0]  addr  = '0;
    logic         cyc   = 1'b0;
    logic         stb   = 1'b0;
    logic         we    = 1'b0;
    logic [31:0]  rdata;
    logic         ack;
    logic         err;
    logic [3:0]   s_stb;
    logic [127:0] s_data = '0;
    logic [3:0]   s_ack  = '0;
    logic         busy;

    // Second DUT: 3 slaves, for the unmapped-select case
    logic [31:0]  m3_addr = '0;
    logic         m3_cyc  = 1'b0;
    logic         m3_stb  = 1'b0;
    logic [31:0]  r3_data;
    logic         r3_ack;
    logic         r3_err;
    logic [2:0]   s3_stb;
    logic [95:0]  s3_data = '0;
    logic [2:0]   s3_ack  = '0;
    logic         r3_busy;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    wb_slave_mux #(.N_SLAVES(4), .SEL_LO(16), .SEL_W(2), .TIMEOUT(8)) dut (
        .clock(clock), .reset(reset),
        .wb_data_i(wdata), .wb_addr_i(addr), .wb_cyc_i(cyc),
        .wb_strobe_i(stb), .wb_we_i(we),
        .wb_data_o(rdata), .wb_ack_o(ack), .wb_err_o(err),
        .s_strobe_o(s_stb), .s_data_i(s_data), .s_ack_i(s_ack),
        .busy_o(busy)
    );

    wb_slave_mux #(.N_SLAVES(3), .SEL_LO(16), .SEL_W(2), .TIMEOUT(8)) dut3 (
        .clock(clock), .reset(reset),
        .wb_data_i(32'h0), .wb_addr_i(m3_addr), .wb_cyc_i(m3_cyc),
        .wb_strobe_i(m3_stb), .wb_we_i(1'b0),
        .wb_data_o(r3_data), .wb_ack_o(r3_ack), .wb_err_o(r3_err),
        .s_strobe_o(s3_stb), .s_data_i(s3_data), .s_ack_i(s3_ack),
        .busy_o(r3_busy)
    );

    typedef struct {
        logic [31:0]  addr;
        logic         we;
        logic [3:0]   ack_mask;   // slaves that ack
        int           ack_cyc;    // cycle of the ack (1 = first strobe cycle, 0 = never)
        logic [127:0] sdata;      // {s3, s2, s1, s0}
        logic [3:0]   exp_stb;
        logic         exp_err;
        int           exp_lat;    // cycle of ack/err after the request cycle
        logic [31:0]  exp_data;
        int           exp_nstb;   // cycles with a strobe high
    } vec_t;

    vec_t vecs[11];
    logic [31:0] exp_last;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic run_txn(input vec_t v, input int idx);
        int   lat = 0;
        int   nstb = 0;
        logic bad = 1'b0;
        logic got_ack = 1'b0;
        logic got_err = 1'b0;
        logic [31:0] got_data = '0;
        s_data = v.sdata;
        s_ack  = '0;
        addr   = v.addr;
        we     = v.we;
        wdata  = ~v.addr;
        cyc    = 1'b1;
        stb    = 1'b1;
        for (int c = 1; c <= 30 && lat == 0; c++) begin
            tick();
            s_ack = (c == v.ack_cyc) ? v.ack_mask : 4'b0000;
            #1;
            if (ack || err) begin
                lat      = c;
                got_ack  = ack;
                got_err  = err;
                got_data = rdata;
            end else if (s_stb != 4'b0000) begin
                nstb++;
                if (s_stb !== v.exp_stb) bad = 1'b1;
            end
        end
        cyc   = 1'b0;
        stb   = 1'b0;
        s_ack = '0;
        chk($sformatf("v%0d latency", idx), 32'(lat), 32'(v.exp_lat));
        chk($sformatf("v%0d ack", idx), 32'(got_ack), 32'(!v.exp_err));
        chk($sformatf("v%0d err", idx), 32'(got_err), 32'(v.exp_err));
        chk($sformatf("v%0d data", idx), got_data, v.exp_data);
        chk($sformatf("v%0d strobe_cycles", idx), 32'(nstb), 32'(v.exp_nstb));
        chk($sformatf("v%0d wrong_strobe", idx), 32'(bad), 32'(0));
        tick();
        chk($sformatf("v%0d single_pulse", idx), 32'(ack | err), 32'(0));
        chk($sformatf("v%0d idle_busy", idx), 32'(busy), 32'(0));
        exp_last = v.exp_data;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //        addr          we    mask     cyc sdata {s3,s2,s1,s0}                                                  stb      err   lat data           nstb
        vecs[0]  = '{32'h0001_0004, 1'b0, 4'b0010, 2, {32'h3333_3333, 32'h2222_2222, 32'hDEAD_BEEF, 32'h1111_1111}, 4'b0010, 1'b0, 3, 32'hDEAD_BEEF, 2};
        vecs[1]  = '{32'h0000_0010, 1'b0, 4'b0001, 1, {32'h0, 32'h0, 32'h0, 32'hA5A5_0000},                       4'b0001, 1'b0, 2, 32'hA5A5_0000, 1};
        vecs[2]  = '{32'h0002_0000, 1'b0, 4'b0101, 1, {32'h0, 32'h2222_CAFE, 32'h0, 32'h0000_0BAD},               4'b0100, 1'b0, 2, 32'h2222_CAFE, 1};
        vecs[3]  = '{32'h0003_0008, 1'b1, 4'b1000, 3, {32'h3333_F00D, 32'h0, 32'h0, 32'h0},                       4'b1000, 1'b0, 4, 32'h3333_F00D, 3};
        vecs[4]  = '{32'h0001_0000, 1'b0, 4'b0100, 1, {32'h0, 32'h4444_4444, 32'h0, 32'h0},                       4'b0010, 1'b1, 9, 32'h0,         8};
        vecs[5]  = '{32'h0000_0000, 1'b0, 4'b0000, 0, {32'h0, 32'h0, 32'h0, 32'h5A5A_5A5A},                       4'b0001, 1'b1, 9, 32'h0,         8};
        vecs[6]  = '{32'h0000_0000, 1'b0, 4'b0001, 8, {32'h0, 32'h0, 32'h0, 32'h0F0F_0F0F},                       4'b0001, 1'b0, 9, 32'h0F0F_0F0F, 8};
        vecs[7]  = '{32'h0002_0000, 1'b0, 4'b0100, 9, {32'h0, 32'h5555_5555, 32'h0, 32'h0},                       4'b0100, 1'b1, 9, 32'h0,         8};
        vecs[8]  = '{32'hFFFC_FFFF, 1'b0, 4'b0001, 1, {32'h0, 32'h0, 32'h0, 32'h1234_5678},                       4'b0001, 1'b0, 2, 32'h1234_5678, 1};
        vecs[9]  = '{32'h0003_0000, 1'b0, 4'b1000, 1, {32'h3333_AAAA, 32'h0, 32'h0, 32'h0},                       4'b1000, 1'b0, 2, 32'h3333_AAAA, 1};
        vecs[10] = '{32'h0000_0000, 1'b0, 4'b0001, 1, {32'h0, 32'h0, 32'h0, 32'hBEEF_0001},                       4'b0001, 1'b0, 2, 32'hBEEF_0001, 1};
        exp_last = '0;

        // Reset state
        #2 reset = 1'b0;
        tick();
        tick();
        chk("reset data", rdata, 32'h0);
        chk("reset ack_err", 32'({ack, err}), 32'h0);
        chk("reset strobe", 32'(s_stb), 32'h0);
        chk("reset busy", 32'(busy), 32'h0);
        reset = 1'b1;
        tick();
        chk("post_reset busy", 32'(busy), 32'h0);

        for (int i = 0; i <= 8; i++) begin
            run_txn(vecs[i], i);
        end

        // Acks in IDLE (late acks) never produce a response
        for (int c = 0; c < 3; c++) begin
            s_ack = 4'b0101;
            tick();
            chk($sformatf("idle_ack%0d pulse", c), 32'({ack, err}), 32'h0);
            chk($sformatf("idle_ack%0d busy", c), 32'(busy), 32'h0);
        end
        s_ack = '0;

        // Abort: drop cyc in BUSY, data must stay
        s_data = {32'h0, 32'h0, 32'h9999_9999, 32'h0};
        addr = 32'h0001_0000;
        cyc = 1'b1;
        stb = 1'b1;
        tick();
        chk("abort busy", 32'(busy), 32'h1);
        chk("abort strobe", 32'(s_stb), 32'h2);
        tick();
        cyc = 1'b0;
        stb = 1'b0;
        #1;
        chk("abort strobe_drop", 32'(s_stb), 32'h0);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("abort%0d pulse", c), 32'({ack, err}), 32'h0);
            chk($sformatf("abort%0d busy", c), 32'(busy), 32'h0);
            chk($sformatf("abort%0d data", c), rdata, exp_last);
        end
        run_txn(vecs[9], 9);

        // Reset during BUSY
        s_data = {32'h0, 32'h6666_6666, 32'h0, 32'h0};
        addr = 32'h0002_0000;
        cyc = 1'b1;
        stb = 1'b1;
        tick();
        chk("rst_mid busy_before", 32'(busy), 32'h1);
        chk("rst_mid strobe_before", 32'(s_stb), 32'h4);
        #2 reset = 1'b0;
        #1;
        chk("rst_mid busy", 32'(busy), 32'h0);
        chk("rst_mid strobe", 32'(s_stb), 32'h0);
        chk("rst_mid data", rdata, 32'h0);
        chk("rst_mid ack_err", 32'({ack, err}), 32'h0);
        cyc = 1'b0;
        stb = 1'b0;
        s_ack = 4'b0100;
        tick();
        chk("rst_hold pulse", 32'({ack, err}), 32'h0);
        s_ack = '0;
        reset = 1'b1;
        tick();
        run_txn(vecs[10], 10);

        // Unmapped select on the 3-slave instance, after a good read
        m3_addr = 32'h0002_0000;
        m3_cyc = 1'b1;
        m3_stb = 1'b1;
        tick();
        s3_ack = 3'b100;
        s3_data = {32'h7777_7777, 32'h0, 32'h0};
        #1;
        chk("n3 read strobe", 32'(s3_stb), 32'h4);
        tick();
        chk("n3 read ack", 32'({r3_ack, r3_err}), 32'h2);
        chk("n3 read data", r3_data, 32'h7777_7777);
        s3_ack = '0;
        m3_cyc = 1'b0;
        m3_stb = 1'b0;
        tick();
        m3_addr = 32'h0003_0000;
        m3_cyc = 1'b1;
        m3_stb = 1'b1;
        #1;
        chk("n3 unmapped strobe_c0", 32'(s3_stb), 32'h0);
        tick();
        chk("n3 unmapped err", 32'({r3_ack, r3_err}), 32'h1);
        chk("n3 unmapped strobe", 32'(s3_stb), 32'h0);
        chk("n3 unmapped data", r3_data, 32'h0);
        chk("n3 unmapped busy", 32'(r3_busy), 32'h1);
        m3_cyc = 1'b0;
        m3_stb = 1'b0;
        tick();
        chk("n3 unmapped single_pulse", 32'({r3_ack, r3_err}), 32'h0);
        chk("n3 unmapped idle", 32'(r3_busy), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
